muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath execute stage, parametrised in operand width.
- Executes MULT, MULTU, DIV and DIVU, selected by the 8-bit ALU control code produced by the ALU decoder.
- Produces a HI/LO result pair after a fixed multi-cycle latency, using a start/busy/ready handshake and an annul input for pipeline flush.
- The datapath stalls on busy_o and writes HI/LO on ready_o.

Parameters:
- WIDTH, 32, operand width in bits. Must be even and >= 4. Latency and the iteration count scale with WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous reset, active-low.
- start_i  in  1  request to begin an operation; sampled only in IDLE.
- op_i  in  8  ALU control code: `EXE_MULT_OP, `EXE_MULTU_OP, `EXE_DIV_OP or `EXE_DIVU_OP.
- a_i  in  WIDTH  multiplicand or dividend.
- b_i  in  WIDTH  multiplier or divisor.
- annul_i  in  1  abort the current operation (flush).
- busy_o  out  1  high whenever state != IDLE.
- ready_o  out  1  one-cycle pulse; hi_o/lo_o carry a new result.
- hi_o  out  WIDTH  multiply: product upper half; divide: remainder.
- lo_o  out  WIDTH  multiply: product lower half; divide: quotient.
- div_by_zero_o  out  1  valid with ready_o; high when a divide had b == 0.

Behaviour:
- Reset: resetn low at a clock edge forces state IDLE, and all outputs and internal registers to 0. Reset mid-operation abandons the operation with no ready_o.
- State machine:
  - IDLE -> MUL on start_i with a MULT/MULTU code.
  - IDLE -> DIV on start_i with a DIV/DIVU code and b_i != 0.
  - IDLE -> DONE on start_i with a DIV/DIVU code and b_i == 0.
  - MUL/DIV -> DONE after WIDTH iterations.
  - DONE -> IDLE unconditionally.
- Start rules: start_i with any other op_i code is ignored (stays IDLE). start_i while busy is ignored.
- Operand capture: operands and op are latched at the start edge. Later changes on a_i/b_i/op_i have no effect.
- Signed ops: operate on magnitudes, sign-correct in the MUL/DIV->DONE transition.
  - Product sign = a[MSB]^b[MSB].
  - Quotient sign = a[MSB]^b[MSB].
  - Remainder sign = a[MSB].
  - Unsigned ops take the operands as-is.
- Multiply: radix-2 shift-add, one partial product per cycle, 2*WIDTH-bit accumulator. {hi_o, lo_o} = full product.
- Divide: radix-2 restoring, one quotient bit per cycle, WIDTH+1-bit partial remainder.
- Latency: if start is accepted at edge t, ready_o is high in the cycle after edge t+WIDTH (WIDTH+1 cycles after the start cycle). Divide-by-zero: ready_o is high in the cycle after edge t.
- Divide by zero: lo_o = all ones, hi_o = a_i, div_by_zero_o = 1.
- Signed overflow: -2^(WIDTH-1) / -1 gives lo_o = 2^(WIDTH-1) bit pattern and hi_o = 0, with no flag.
- ready_o and div_by_zero_o are high only in DONE.
- hi_o/lo_o are registered and hold the last result until the next DONE. They are not cleared by a new start.
- annul_i:
  - In any state, the next state is IDLE.
  - No ready_o is produced, and hi_o/lo_o/div_by_zero_o keep their previous values.
  - annul_i together with start_i in IDLE: annul wins and the start is dropped.
  - annul_i in DONE: ready_o is still high that cycle, since the result is already committed.
- Iteration counter is log2(WIDTH)+1 bits, loaded with WIDTH-1 and counting down to 0. No wrap-around beyond 0.

Decomposition:
- defines.vh (shared): `EXE_MULT_OP, `EXE_MULTU_OP, `EXE_DIV_OP, `EXE_DIVU_OP codes, and the state encodings MDU_IDLE/MUL/DIV/DONE (2-bit).
- Sub-module div_step: combinational single restoring-division iteration, parametrised by WIDTH.
  - Inputs: partial remainder, divisor, dividend bit.
  - Outputs: next partial remainder, quotient bit.
  - Reused for a future radix-4 version.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF (WIDTH=32) -> hi_o=0xFFFFFFFE, lo_o=0x00000001; ready_o exactly 33 cycles after the start cycle; busy_o high for 33 cycles.
- MULT 0xFFFFFFFD x 0x00000007 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB.
- DIV 0xFFFFFFF9 / 0x00000002 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU with the same operands -> lo_o=0x7FFFFFFC, hi_o=0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0, div_by_zero_o=0. DIVU 5 / 0 -> ready_o in the cycle after start, lo_o=0xFFFFFFFF, hi_o=5, div_by_zero_o=1.
- MULT started; annul_i at iteration 10 -> busy_o low next cycle, no ready_o, hi_o/lo_o unchanged from the prior result. start_i pulsed mid-operation is ignored, with no second ready_o.
- resetn low at iteration 5 of a DIV -> all outputs 0 next cycle, state IDLE. A new start after reset release completes normally.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - ALU control codes accepted by muldiv_unit (from the ALU decoder)
//   - FSM state encoding
//   - small op-classification helpers
package muldiv_unit_pkg;

  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_MUL  = 2'b01,
    MDU_DIV  = 2'b10,
    MDU_DONE = 2'b11
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
  endfunction

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

  function automatic logic is_signed_op(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration (combinational).
// Ports:
//   rem_i          partial remainder (WIDTH+1 bits)
//   divisor_i      divisor magnitude
//   dividend_bit_i next dividend bit shifted into the remainder
//   rem_o          next partial remainder
//   q_bit_o        quotient bit produced by this iteration
module muldiv_unit_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             dividend_bit_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // One extra bit of headroom so the borrow out of the trial subtract
  // lands in diff's MSB and directly gives the (inverted) quotient bit.
  assign shifted = {rem_i, dividend_bit_i};
  assign diff    = shifted - {2'b00, divisor_i};
  assign q_bit_o = ~diff[WIDTH+1];
  assign rem_o   = q_bit_o ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the execute stage.
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   start_i, op_i         start request and ALU control code (sampled in IDLE)
//   a_i, b_i              multiplicand/dividend, multiplier/divisor
//   annul_i               flush: return to IDLE without producing a result
//   busy_o                operation in flight (state != IDLE)
//   ready_o               one-cycle pulse, hi_o/lo_o hold a new result
//   hi_o, lo_o            product high/low, or remainder/quotient
//   div_by_zero_o         qualifies ready_o for a divide by zero
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [7:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // mul: {partial sum, multiplier}; div: low half = dividend/quotient
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic               neg_q, neg_d;     // negate product / quotient
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               op_sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH:0]     div_rem;
  logic               q_bit;
  logic [WIDTH-1:0]   div_quo;

  assign op_sgn = is_signed_op(op_i);
  assign a_mag  = (op_sgn && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag  = (op_sgn && b_i[WIDTH-1]) ? -b_i : b_i;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

  muldiv_unit_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i          (rem_q),
    .divisor_i      (opnd_q),
    .dividend_bit_i (acc_q[WIDTH-1]),
    .rem_o          (div_rem),
    .q_bit_o        (q_bit)
  );

  assign div_quo = {acc_q[WIDTH-2:0], q_bit};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;

    case (state_q)
      MDU_IDLE: begin
        if (start_i && is_mul_op(op_i)) begin
          state_d = MDU_MUL;
          cnt_d   = CNT_LOAD;
          opnd_d  = a_mag;
          acc_d   = {{WIDTH{1'b0}}, b_mag};
          neg_d   = op_sgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        end else if (start_i && is_div_op(op_i)) begin
          if (b_i == '0) begin
            state_d = MDU_DONE;
            hi_d    = a_i;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d   = MDU_DIV;
            cnt_d     = CNT_LOAD;
            opnd_d    = b_mag;
            acc_d     = {{WIDTH{1'b0}}, a_mag};
            rem_d     = '0;
            neg_d     = op_sgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_rem_d = op_sgn && a_i[WIDTH-1];
          end
        end
      end
      MDU_MUL: begin
        acc_d = mul_acc;
        if (cnt_q == '0) begin
          state_d      = MDU_DONE;
          {hi_d, lo_d} = neg_q ? -mul_acc : mul_acc;
          dbz_d        = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      MDU_DIV: begin
        acc_d = {acc_q[2*WIDTH-1:WIDTH], div_quo};
        rem_d = div_rem;
        if (cnt_q == '0) begin
          state_d = MDU_DONE;
          lo_d    = neg_q ? -div_quo : div_quo;
          hi_d    = neg_rem_q ? -div_rem[WIDTH-1:0] : div_rem[WIDTH-1:0];
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = MDU_IDLE;
      end
    endcase

    // Flush overrides everything, including a start in IDLE and the final
    // iteration's result write.
    if (annul_i) begin
      state_d = MDU_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  // ready/flag follow the DONE state so a flush during DONE still shows the
  // already-committed result for that cycle.
  assign busy_o        = (state_q != MDU_IDLE);
  assign ready_o       = (state_q == MDU_DONE);
  assign div_by_zero_o = dbz_q && (state_q == MDU_DONE);
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start_i;
  logic [7:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         annul_i;
  logic         busy_o;
  logic         ready_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic         div_by_zero_o;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start_i       (start_i),
    .op_i          (op_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .annul_i       (annul_i),
    .busy_o        (busy_o),
    .ready_o       (ready_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
  function automatic void model(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
    longint sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    dbz = 1'b0;
    hi = '0;
    lo = '0;
    if (op == EXE_MULT_OP) begin
      sp = sa * sb;
      hi = sp[63:32];
      lo = sp[31:0];
    end else if (op == EXE_MULTU_OP) begin
      up = ua * ub;
      hi = up[63:32];
      lo = up[31:0];
    end else if (b == '0) begin
      dbz = 1'b1;
      hi  = a;
      lo  = '1;
    end else if (op == EXE_DIV_OP) begin
      sq = sa / sb;
      sr = sa % sb;
      hi = sr[31:0];
      lo = sq[31:0];
    end else begin
      uq = ua / ub;
      ur = ua % ub;
      hi = ur[31:0];
      lo = uq[31:0];
    end
  endfunction

  // Starts an op, scrambles the inputs afterwards, and waits (bounded) for ready.
  task automatic do_op(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy_cnt);
    int l, bc;
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
    op_i = 8'($urandom);
    l = 0;
    bc = 0;
    while (!ready_o && l < 100) begin
      if (busy_o) bc++;
      tick();
      l++;
    end
    if (busy_o) bc++;
    lat = l;
    busy_cnt = bc;
  endtask

  task automatic run_check(input string tag, input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ehi, elo;
    logic edbz;
    int lat, bc, elat;
    model(op, a, b, ehi, elo, edbz);
    elat = (edbz) ? 0 : W;
    do_op(op, a, b, lat, bc);
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_busy"}, 64'(bc), 64'(elat + 1));
    check({tag, "_hi"}, 64'(hi_o), 64'(ehi));
    check({tag, "_lo"}, 64'(lo_o), 64'(elo));
    check({tag, "_dbz"}, 64'(div_by_zero_o), 64'(edbz));
    tick();
    check({tag, "_ready_pulse"}, 64'(ready_o), 64'(0));
    check({tag, "_idle"}, 64'(busy_o), 64'(0));
    last_hi = ehi;
    last_lo = elo;
  endtask

  initial begin
    logic [7:0]   rop;
    logic [W-1:0] ra, rb;
    logic [W-1:0] ehi, elo;
    logic edbz;
    int n_ready;
    logic [W-1:0] cap_hi, cap_lo;
    logic [7:0] ops [4];
    ops[0] = EXE_MULT_OP; ops[1] = EXE_MULTU_OP; ops[2] = EXE_DIV_OP; ops[3] = EXE_DIVU_OP;

    resetn = 1'b0; start_i = 1'b0; annul_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    tick();
    tick();
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_ready", 64'(ready_o), 64'(0));
    check("rst_hi", 64'(hi_o), 64'(0));
    check("rst_lo", 64'(lo_o), 64'(0));
    check("rst_dbz", 64'(div_by_zero_o), 64'(0));
    resetn = 1'b1;
    tick();

    // Directed vectors
    run_check("multu_ones", EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_ones_hi_const", 64'(hi_o), 64'h0000_0000_FFFF_FFFE);
    run_check("mult_neg", EXE_MULT_OP, 32'hFFFF_FFFD, 32'h0000_0007);
    check("mult_neg_lo_const", 64'(lo_o), 64'h0000_0000_FFFF_FFEB);
    run_check("div_neg", EXE_DIV_OP, 32'hFFFF_FFF9, 32'h0000_0002);
    run_check("divu_big", EXE_DIVU_OP, 32'hFFFF_FFF9, 32'h0000_0002);
    check("divu_big_lo_const", 64'(lo_o), 64'h0000_0000_7FFF_FFFC);
    run_check("div_ovf", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo_const", 64'(lo_o), 64'h0000_0000_8000_0000);
    run_check("divu_zero", EXE_DIVU_OP, 32'h0000_0005, 32'h0000_0000);
    run_check("div_neg_zero", EXE_DIV_OP, 32'h8000_0001, 32'h0000_0000);

    // Unknown op code is ignored
    op_i = 8'h20; a_i = 32'd3; b_i = 32'd4; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("badop_idle", 64'(busy_o), 64'(0));

    // Annul together with start in IDLE drops the start
    op_i = EXE_MULTU_OP; start_i = 1'b1; annul_i = 1'b1;
    tick();
    start_i = 1'b0; annul_i = 1'b0;
    check("annul_start_idle", 64'(busy_o), 64'(0));

    // Annul at iteration 10 of a MULT
    op_i = EXE_MULT_OP; a_i = 32'h1234_5678; b_i = 32'h9ABC_DEF0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    check("annul_busy", 64'(busy_o), 64'(0));
    check("annul_hi_kept", 64'(hi_o), 64'(last_hi));
    check("annul_lo_kept", 64'(lo_o), 64'(last_lo));
    n_ready = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o) n_ready++;
      tick();
    end
    check("annul_no_ready", 64'(n_ready), 64'(0));

    // Start pulsed mid-operation is ignored
    model(EXE_MULTU_OP, 32'hDEAD_BEEF, 32'h0000_1001, ehi, elo, edbz);
    op_i = EXE_MULTU_OP; a_i = 32'hDEAD_BEEF; b_i = 32'h0000_1001; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    op_i = EXE_DIVU_OP; a_i = 32'd9; b_i = 32'd0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n_ready = 0; cap_hi = '0; cap_lo = '0;
    for (int i = 0; i < 60; i++) begin
      if (ready_o) begin
        n_ready++;
        cap_hi = hi_o;
        cap_lo = lo_o;
      end
      tick();
    end
    check("midstart_one_ready", 64'(n_ready), 64'(1));
    check("midstart_hi", 64'(cap_hi), 64'(ehi));
    check("midstart_lo", 64'(cap_lo), 64'(elo));
    last_hi = ehi; last_lo = elo;

    // Annul during DONE: ready still shown that cycle, result kept
    begin
      int lat, bc;
      model(EXE_DIVU_OP, 32'd1000, 32'd7, ehi, elo, edbz);
      do_op(EXE_DIVU_OP, 32'd1000, 32'd7, lat, bc);
      annul_i = 1'b1;
      #1;
      check("annul_done_ready", 64'(ready_o), 64'(1));
      tick();
      annul_i = 1'b0;
      check("annul_done_idle", 64'(busy_o), 64'(0));
      check("annul_done_lo", 64'(lo_o), 64'(elo));
      check("annul_done_hi", 64'(hi_o), 64'(ehi));
    end

    // Reset at iteration 5 of a DIV
    op_i = EXE_DIV_OP; a_i = 32'hF000_0001; b_i = 32'd3; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("midrst_busy", 64'(busy_o), 64'(0));
    check("midrst_ready", 64'(ready_o), 64'(0));
    check("midrst_hi", 64'(hi_o), 64'(0));
    check("midrst_lo", 64'(lo_o), 64'(0));
    check("midrst_dbz", 64'(div_by_zero_o), 64'(0));
    run_check("after_rst", EXE_DIV_OP, 32'hF000_0001, 32'd3);

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      rop = ops[$urandom_range(0, 3)];
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = 32'h8000_0000;
        2: rb = 32'(($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1);
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_check("rand", rop, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
